// File: rtl/dht22_sensor_emu.sv
// DHT22 sensor emulator: answers a host start pulse on the open-drain line with the
// 80us/80us handshake and one 40-bit frame {humidity, temperature, parity}.
module dht22_sensor_emu #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int MIN_START_US = 800,
    parameter int RESP_DLY_US  = 30
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        load,
    input  logic [15:0] humidity_in,
    input  logic [15:0] temperature_in,
    input  logic        inject_parity_err,
    inout  wire         dht22_in_out,
    output logic        busy,
    output logic        frame_done,
    output logic        short_start,
    output logic [15:0] frames_sent
);

    localparam int TPU = CLK_FREQ / 1_000_000;
    localparam int TW  = $clog2(1000 * TPU) + 1;

    // Reload values are duration-1 so each state lasts exactly its duration in ticks.
    localparam logic [TW-1:0] T_RESP_DLY = TW'(RESP_DLY_US * TPU - 1);
    localparam logic [TW-1:0] T_80       = TW'(80 * TPU - 1);
    localparam logic [TW-1:0] T_70       = TW'(70 * TPU - 1);
    localparam logic [TW-1:0] T_50       = TW'(50 * TPU - 1);
    localparam logic [TW-1:0] T_26       = TW'(26 * TPU - 1);
    localparam logic [TW-1:0] T_MIN      = TW'(MIN_START_US * TPU);

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [5:0]    bit_idx, bit_idx_n;
    logic [1:0]    sync_ff;
    logic          line_sync, line_prev, line_fall, line_rise, expired;
    logic [15:0]   shadow_hum, shadow_temp;
    logic          err_flag;
    logic [39:0]   frame;
    logic [7:0]    parity;
    logic          latch, done_n, short_n, drive_low;

    assign line_sync = sync_ff[1];
    assign line_fall = line_prev & ~line_sync;
    assign line_rise = ~line_prev & line_sync;
    assign expired   = (timer == '0);
    assign parity    = (shadow_hum[15:8] + shadow_hum[7:0] + shadow_temp[15:8] + shadow_temp[7:0])
                       ^ {8{err_flag}};

    // Open-drain: only the enable toggles, so the line can never be driven high.
    assign drive_low    = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
    assign dht22_in_out = drive_low ? 1'b0 : 1'bz;
    assign busy         = !((state == IDLE) || (state == HOST_LOW));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        timer_n   = expired ? timer : timer - 1'b1;
        bit_idx_n = bit_idx;
        latch     = 1'b0;
        done_n    = 1'b0;
        short_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (line_fall) begin
                    state_n = HOST_LOW;
                    timer_n = TW'(1);
                end
            end
            HOST_LOW: begin
                timer_n = (&timer) ? timer : timer + 1'b1;
                if (line_rise) begin
                    if (timer >= T_MIN) begin
                        state_n = RESP_DLY;
                        timer_n = T_RESP_DLY;
                        latch   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                        short_n = 1'b1;
                    end
                end
            end
            RESP_DLY: if (expired) begin
                state_n = RESP_LOW;
                timer_n = T_80;
            end
            RESP_LOW: if (expired) begin
                state_n = RESP_HIGH;
                timer_n = T_80;
            end
            RESP_HIGH: if (expired) begin
                state_n   = BIT_LOW;
                timer_n   = T_50;
                bit_idx_n = 6'd39;
            end
            BIT_LOW: if (expired) begin
                state_n = BIT_HIGH;
                timer_n = frame[bit_idx] ? T_70 : T_26;
            end
            BIT_HIGH: if (expired) begin
                timer_n = T_50;
                if (bit_idx == 6'd0) begin
                    state_n = END_LOW;
                end else begin
                    state_n   = BIT_LOW;
                    bit_idx_n = bit_idx - 1'b1;
                end
            end
            END_LOW: if (expired) begin
                state_n = IDLE;
                timer_n = '0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync_ff     <= 2'b11;
            line_prev   <= 1'b1;
            shadow_hum  <= '0;
            shadow_temp <= '0;
            err_flag    <= 1'b0;
            frame       <= '0;
            frame_done  <= 1'b0;
            short_start <= 1'b0;
            frames_sent <= '0;
        end else begin
            sync_ff     <= {sync_ff[0], dht22_in_out};
            line_prev   <= line_sync;
            frame_done  <= done_n;
            short_start <= short_n;
            if (load) begin
                shadow_hum  <= humidity_in;
                shadow_temp <= temperature_in;
            end
            // A strobe coinciding with the latch survives and applies to the next frame.
            if (latch) begin
                frame    <= {shadow_hum, shadow_temp, parity};
                err_flag <= 1'b0;
            end
            if (inject_parity_err) err_flag <= 1'b1;
            if (done_n) frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Self-checking bench for dht22_sensor_emu: a host model issues start pulses, measures the
// line run lengths and decodes each frame against a spec-level shadow/parity model.
module tb_dht22_sensor_emu;

    localparam int CLK_FREQ     = 1_000_000;
    localparam int MIN_START_US = 800;
    localparam int RESP_DLY_US  = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        inject = 1'b0;
    logic        host_low = 1'b0;
    logic [15:0] hum_in = '0;
    logic [15:0] temp_in = '0;
    logic        busy, frame_done, short_start;
    logic [15:0] frames_sent;
    wire         dht22_line;

    pullup (dht22_line);
    assign dht22_line = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht22_sensor_emu #(
        .CLK_FREQ    (CLK_FREQ),
        .MIN_START_US(MIN_START_US),
        .RESP_DLY_US (RESP_DLY_US)
    ) dut (
        .S_AXI_ACLK       (clk),
        .S_AXI_ARESETN    (rst_n),
        .load             (load),
        .humidity_in      (hum_in),
        .temperature_in   (temp_in),
        .inject_parity_err(inject),
        .dht22_in_out     (dht22_line),
        .busy             (busy),
        .frame_done       (frame_done),
        .short_start      (short_start),
        .frames_sent      (frames_sent)
    );

    // Reference model state: what the sensor should hold according to the protocol rules.
    logic [15:0] m_hum = '0;
    logic [15:0] m_temp = '0;
    bit          m_err = 1'b0;
    int          m_frames = 0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        n_cmp++;
        assert ((val >= lo && val <= hi) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    // Sample point: just after the falling clock edge; strobes last exactly one cycle.
    task automatic tick();
        @(negedge clk);
        #1;
        load   = 1'b0;
        inject = 1'b0;
    endtask

    task automatic count_run(input logic level, input int limit, output int n);
        n = 0;
        while (dht22_line === level && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic do_load(input logic [15:0] h, input logic [15:0] t);
        hum_in  = h;
        temp_in = t;
        load    = 1'b1;
        m_hum   = h;
        m_temp  = t;
        tick();
    endtask

    task automatic do_inject();
        inject = 1'b1;
        m_err  = 1'b1;
        tick();
    endtask

    function automatic logic [39:0] model_frame();
        int sum;
        logic [7:0] p;
        sum = (int'(m_hum) / 256) + (int'(m_hum) % 256) + (int'(m_temp) / 256) + (int'(m_temp) % 256);
        p = 8'(sum % 256);
        if (m_err) p = ~p;
        return {m_hum, m_temp, p};
    endfunction

    task automatic host_start(input int low_len);
        host_low = 1'b1;
        repeat (low_len) tick();
        host_low = 1'b0;
    endtask

    task automatic run_frame(input string name, input int low_len, input bit mid_load,
                             input logic [15:0] nh, input logic [15:0] nt);
        logic [39:0] exp_f, got;
        int d, a, b, lo, hi, e;
        exp_f = model_frame();
        m_err = 1'b0;
        got   = '0;
        host_start(low_len);
        tick();
        count_run(1'b1, 100, d);
        check_range({name, "_resp_dly"}, d, RESP_DLY_US, RESP_DLY_US + 4);
        if (d >= 100) return;
        check({name, "_busy_in_frame"}, 64'(busy), 64'd1);
        count_run(1'b0, 200, a);
        check_range({name, "_hs_low"}, a, 79, 81);
        count_run(1'b1, 200, b);
        check_range({name, "_hs_high"}, b, 79, 81);
        for (int i = 39; i >= 0; i--) begin
            if (mid_load && i == 20) begin
                hum_in  = nh;
                temp_in = nt;
                load    = 1'b1;
                m_hum   = nh;
                m_temp  = nt;
            end
            count_run(1'b0, 200, lo);
            check_range($sformatf("%s_bit%0d_low", name, i), lo, 49, 51);
            count_run(1'b1, 200, hi);
            got[i] = (hi > 48);
            if (got[i]) check_range($sformatf("%s_bit%0d_high1", name, i), hi, 69, 71);
            else        check_range($sformatf("%s_bit%0d_high0", name, i), hi, 25, 27);
        end
        count_run(1'b0, 200, e);
        check_range({name, "_end_low"}, e, 49, 51);
        check({name, "_frame"}, 64'(got), 64'(exp_f));
        m_frames++;
        check({name, "_frame_done"}, 64'(frame_done), 64'd1);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_frames_sent"}, 64'(frames_sent), 64'(16'(m_frames)));
        tick();
        check({name, "_frame_done_pulse"}, 64'(frame_done), 64'd0);
    endtask

    task automatic short_test(input string name, input int low_len);
        bit seen, drove, was_busy;
        seen = 0;
        drove = 0;
        was_busy = 0;
        host_start(low_len);
        repeat (10) begin
            tick();
            if (short_start) seen = 1;
        end
        check({name, "_short_start"}, 64'(seen), 64'd1);
        repeat (100) begin
            tick();
            if (dht22_line !== 1'b1) drove = 1;
            if (busy) was_busy = 1;
        end
        check({name, "_line_released"}, 64'(drove), 64'd0);
        check({name, "_busy_low"}, 64'(was_busy), 64'd0);
        check({name, "_frames_sent"}, 64'(frames_sent), 64'(16'(m_frames)));
    endtask

    initial begin
        int d;
        repeat (3) tick();
        check("reset_line", 64'(dht22_line), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frames", 64'(frames_sent), 64'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        do_load(16'h028C, 16'h0119);
        run_frame("t1", 1000, 1'b0, '0, '0);

        do_load(16'h0000, 16'h8065);
        run_frame("t2", 1000, 1'b0, '0, '0);

        short_test("t3_500", 500);
        short_test("t3_799", 799);

        do_load(16'h028C, 16'h0119);
        do_inject();
        run_frame("t4_err", 1000, 1'b0, '0, '0);
        run_frame("t4_clean", 1000, 1'b0, '0, '0);

        do_load(16'h1234, 16'h00F0);
        run_frame("t5_cur", 1000, 1'b1, 16'h0301, 16'h80AA);
        run_frame("t5_next", 1000, 1'b0, '0, '0);

        host_start(900);
        tick();
        count_run(1'b1, 100, d);
        repeat (10) tick();
        check("t6_in_resp_low", 64'(dht22_line), 64'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_line", 64'(dht22_line), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(frame_done), 64'd0);
        check("t6_rst_short", 64'(short_start), 64'd0);
        check("t6_rst_frames", 64'(frames_sent), 64'd0);
        m_hum = '0;
        m_temp = '0;
        m_err = 1'b0;
        m_frames = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        run_frame("t6_min_start", MIN_START_US, 1'b0, '0, '0);

        for (int r = 0; r < 2; r++) begin
            do_load(16'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) do_inject();
            run_frame($sformatf("rand%0d", r), (r == 1) ? 2100 : int'($urandom_range(800, 1100)),
                      1'b0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
